alu_decode_stage: RTL and testbench

- Registered decode stage that produces the ALU control interface: alu_control[3:0], equal_comp[1:0], immediate and operand-B select.
- Accepts 32-bit RV32I instructions over a valid/ready handshake.
- Decodes opcode/funct3/funct7 and delivers results through a 2-entry skid buffer to the execute stage.
- Supports stall (backpressure) and flush.

---
 rtl/alu_decode_stage.sv | 211 +++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// RV32I decode stage producing ALU control, immediate and branch compare controls through a 2-entry skid buffer.
// Optional illegal-encoding detection is enabled by defining ALU_DECODE_ILLEGAL_CHECK_EN.
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      alu_control,
  output logic [1:0]      equal_comp,
  output logic            alu_src_imm,
  output logic [XLEN-1:0] imm,
  output logic            is_branch,
  output logic            illegal
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu;
    logic [1:0]      eq;
    logic            src_imm;
    logic [XLEN-1:0] imm;
    logic            br;
    logic            ill;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{pc: '0, alu: ALU_ADD, eq: 2'b00, src_imm: 1'b0,
                                     imm: '0, br: 1'b0, ill: 1'b0};

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  entry_t w_dec;
  entry_t w_entry;
  logic   w_accept;

  entry_t r_out;
  entry_t r_skid;
  logic   r_out_valid;
  logic   r_skid_valid;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u  = {in_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign w_imm_sh = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    w_dec    = RESET_ENTRY;
    w_dec.pc = in_pc;
    case (w_opcode)
      OP_R: w_dec.alu = alu_op(w_funct3, w_funct7[5]);
      OP_IMM: begin
        // funct3=000 has no SUBI, so funct7[5] only selects arithmetic right shift
        w_dec.alu     = alu_op(w_funct3, w_funct7[5] && (w_funct3 == 3'b101));
        w_dec.src_imm = 1'b1;
        w_dec.imm     = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? w_imm_sh : w_imm_i;
      end
      OP_LOAD, OP_JALR: begin
        w_dec.src_imm = 1'b1;
        w_dec.imm     = w_imm_i;
      end
      OP_STORE: begin
        w_dec.src_imm = 1'b1;
        w_dec.imm     = w_imm_s;
      end
      OP_AUIPC, OP_LUI: begin
        w_dec.src_imm = 1'b1;
        w_dec.imm     = w_imm_u;
      end
      OP_JAL: begin
        w_dec.src_imm = 1'b1;
        w_dec.imm     = w_imm_j;
      end
      OP_BRANCH: begin
        w_dec.br  = 1'b1;
        w_dec.imm = w_imm_b;
        // eq = {equal_inequal, comparator_enable}
        case (w_funct3)
          3'b000: begin w_dec.alu = ALU_XOR;  w_dec.eq = 2'b11; end
          3'b001: begin w_dec.alu = ALU_XOR;  w_dec.eq = 2'b01; end
          3'b100: begin w_dec.alu = ALU_SLT;  w_dec.eq = 2'b11; end
          3'b101: begin w_dec.alu = ALU_SLT;  w_dec.eq = 2'b01; end
          3'b110: begin w_dec.alu = ALU_SLTU; w_dec.eq = 2'b11; end
          3'b111: begin w_dec.alu = ALU_SLTU; w_dec.eq = 2'b01; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef ALU_DECODE_ILLEGAL_CHECK_EN
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    case (w_opcode)
      OP_R: w_bad = !((w_funct7 == 7'b0000000) ||
                      (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)));
      OP_IMM: begin
        if (w_funct3 == 3'b001)
          w_bad = (w_funct7 != 7'b0000000);
        else if (w_funct3 == 3'b101)
          w_bad = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
      end
      OP_BRANCH: w_bad = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC, OP_LUI, OP_JAL: w_bad = 1'b0;
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_entry = w_dec;
    if (w_bad) begin
      w_entry     = RESET_ENTRY;
      w_entry.pc  = in_pc;
      w_entry.ill = 1'b1;
    end
  end
`else
  assign w_entry = w_dec;
`endif

  // A full skid implies a full output register, so accept only needs the skid slot
  assign w_accept = in_valid && !r_skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= RESET_ENTRY;
      r_skid       <= RESET_ENTRY;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_entry;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_entry;
      r_skid_valid <= 1'b1;
    end
  end

  assign in_ready    = !r_skid_valid;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out.pc;
  assign alu_control = r_out.alu;
  assign equal_comp  = r_out.eq;
  assign alu_src_imm = r_out.src_imm;
  assign imm         = r_out.imm;
  assign is_branch   = r_out.br;
  assign illegal     = r_out.ill;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized and directed bench for alu_decode_stage: an instruction-level decode model plus a
// queue of in-flight entries is compared with the DUT outputs every cycle.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [3:0]  alu_control;
  logic [1:0]  equal_comp;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic        is_branch;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .alu_control(alu_control),
    .equal_comp(equal_comp), .alu_src_imm(alu_src_imm), .imm(imm),
    .is_branch(is_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [1:0]  eq;
    logic        src;
    logic [31:0] imm;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] code_of(input string mn);
    case (mn)
      "AND": return 4'd0;  "OR":  return 4'd1;  "ADD": return 4'd2;  "XOR":  return 4'd3;
      "SLL": return 4'd4;  "SLT": return 4'd5;  "SUB": return 4'd6;  "SLTU": return 4'd7;
      "SRL": return 4'd8;  "SRA": return 4'd9;
      default: return 4'd2;
    endcase
  endfunction

  function automatic string arith_name(input int f3, input bit alt);
    case (f3)
      0: return alt ? "SUB" : "ADD";
      1: return "SLL";
      2: return "SLT";
      3: return "SLTU";
      4: return "XOR";
      5: return alt ? "SRA" : "SRL";
      6: return "OR";
      default: return "AND";
    endcase
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'(1) << (bits - 1);
    return (v ^ m) - m;
  endfunction

  // Instruction-level reference: name the operation, then map the name to its control code
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    string mn;
    int op, f3, f7;
    bit bad;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    e = '{pc: pc, alu: 4'd2, eq: 2'd0, src: 1'b0, imm: 32'd0, br: 1'b0, ill: 1'b0};
    mn = "ADD";
    bad = 0;
    case (op)
      'h33: begin
        mn = arith_name(f3, ins[30]);
        bad = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
      end
      'h13: begin
        mn = arith_name(f3, ins[30] && f3 == 5);
        e.src = 1;
        if (f3 == 1 || f3 == 5) e.imm = 32'(ins[24:20]);
        else e.imm = sext(32'(ins[31:20]), 12);
        bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20);
      end
      'h03, 'h67: begin e.src = 1; e.imm = sext(32'(ins[31:20]), 12); end
      'h23: begin e.src = 1; e.imm = sext(32'({ins[31:25], ins[11:7]}), 12); end
      'h17, 'h37: begin e.src = 1; e.imm = {ins[31:12], 12'd0}; end
      'h6F: begin
        e.src = 1;
        e.imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      end
      'h63: begin
        e.br = 1;
        e.imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
        case (f3)
          0: begin mn = "XOR";  e.eq = 2'b11; end
          1: begin mn = "XOR";  e.eq = 2'b01; end
          4: begin mn = "SLT";  e.eq = 2'b11; end
          5: begin mn = "SLT";  e.eq = 2'b01; end
          6: begin mn = "SLTU"; e.eq = 2'b11; end
          7: begin mn = "SLTU"; e.eq = 2'b01; end
          default: bad = 1;
        endcase
      end
      default: bad = 1;
    endcase
    e.alu = code_of(mn);
`ifdef ALU_DECODE_ILLEGAL_CHECK_EN
    if (bad) e = '{pc: pc, alu: 4'd2, eq: 2'd0, src: 1'b0, imm: 32'd0, br: 1'b0, ill: 1'b1};
`else
    if (bad && op != 'h63 && op != 'h33 && op != 'h13) e.src = 0;
`endif
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      int sz;
      bit acc, dr;
      sz = q.size();
      acc = in_valid && sz < 2;
      dr = out_ready && sz > 0;
      if (flush) q.delete();
      else begin
        if (dr) void'(q.pop_front());
        if (acc) q.push_back(model(in_instr, in_pc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() == 0) chk("out_valid_idle", 32'(out_valid), 0);
      else begin
        chk("out_valid", 32'(out_valid), 1);
        chk("out_pc", out_pc, q[0].pc);
        chk("alu_control", 32'(alu_control), 32'(q[0].alu));
        chk("equal_comp", 32'(equal_comp), 32'(q[0].eq));
        chk("alu_src_imm", 32'(alu_src_imm), 32'(q[0].src));
        chk("imm", imm, q[0].imm);
        chk("is_branch", 32'(is_branch), 32'(q[0].br));
        chk("illegal", 32'(illegal), 32'(q[0].ill));
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    $display("step v=%0d instr=%08h pc=%08h ordy=%0d flush=%0d -> out_valid=%0d in_ready=%0d alu=%0h",
             v, ins, pc, ordy, fl, out_valid, in_ready, alu_control);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_alu"}, 32'(alu_control), 32'h2);
    chk({tag, "_eq"}, 32'(equal_comp), 0);
    chk({tag, "_src"}, 32'(alu_src_imm), 0);
    chk({tag, "_imm"}, imm, 0);
    chk({tag, "_br"}, 32'(is_branch), 0);
    chk({tag, "_ill"}, 32'(illegal), 0);
    chk({tag, "_pc"}, out_pc, 0);
  endtask

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_SRAI = 32'h40315093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BGE  = 32'h0020D463;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_BR2  = 32'h00002063;

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0] ops [10];
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h17, 7'h37, 7'h6F, 7'h63, 7'h00};
    ins = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) ins[6:0] = ops[k];
    if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(0, 4) != 0)
      ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return ins;
  endfunction

  initial begin
    exp_t m;
    // Pin the reference model to hand-computed values
    m = model(I_SRAI, 0);
    chk("pin_srai_alu", 32'(m.alu), 9);
    chk("pin_srai_imm", m.imm, 3);
    m = model(I_BEQ, 0);
    chk("pin_beq", {20'd0, m.alu, 2'd0, m.eq, 3'd0, m.br}, {20'd0, 4'h3, 2'd0, 2'b11, 3'd0, 1'b1});
    chk("pin_beq_imm", m.imm, 8);
    m = model(32'hFFF00093, 0);
    chk("pin_addi_neg_imm", m.imm, 32'hFFFFFFFF);

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    step(1, I_ADD, 32'h100, 1, 0);
    chk("lat_add_valid", 32'(out_valid), 1);
    chk("lat_add_alu", 32'(alu_control), 32'h2);
    chk("lat_add_src", 32'(alu_src_imm), 0);
    chk("lat_add_eq", 32'(equal_comp), 0);
    step(1, I_SUB, 32'h104, 1, 0);
    chk("sub_alu", 32'(alu_control), 32'h6);
    step(1, I_SRAI, 32'h108, 1, 0);
    chk("srai_alu", 32'(alu_control), 32'h9);
    chk("srai_src", 32'(alu_src_imm), 1);
    chk("srai_imm", imm, 32'h3);
    step(1, I_BEQ, 32'h10C, 1, 0);
    chk("beq_alu", 32'(alu_control), 32'h3);
    chk("beq_eq", 32'(equal_comp), 32'h3);
    chk("beq_br", 32'(is_branch), 1);
    chk("beq_imm", imm, 32'h8);
    step(1, I_BGE, 32'h110, 1, 0);
    chk("bge_alu", 32'(alu_control), 32'h5);
    chk("bge_eq", 32'(equal_comp), 32'h1);
    step(0, 0, 0, 1, 0);
    chk("drained", 32'(out_valid), 0);

    // Backpressure: fill output + skid, hold a third instruction, then release
    step(1, I_ADD, 32'h200, 0, 0);
    chk("bp_ready1", 32'(in_ready), 1);
    step(1, I_SUB, 32'h204, 0, 0);
    chk("bp_ready_full", 32'(in_ready), 0);
    chk("bp_head_add", 32'(alu_control), 32'h2);
    repeat (3) step(1, I_XOR, 32'h208, 0, 0);
    chk("bp_held_ready", 32'(in_ready), 0);
    chk("bp_held_pc", out_pc, 32'h200);
    step(1, I_XOR, 32'h208, 1, 0);
    chk("bp_second_sub", 32'(alu_control), 32'h6);
    chk("bp_second_pc", out_pc, 32'h204);
    step(1, I_XOR, 32'h208, 1, 0);
    chk("bp_third_xor", 32'(alu_control), 32'h3);
    chk("bp_third_pc", out_pc, 32'h208);
    step(0, 0, 0, 1, 0);
    chk("bp_no_dup", 32'(out_valid), 0);

    // Flush with a full buffer and a valid instruction in the same cycle
    step(1, I_ADD, 32'h300, 0, 0);
    step(1, I_SUB, 32'h304, 0, 0);
    step(1, I_XOR, 32'h308, 0, 1);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ready", 32'(in_ready), 1);
    step(0, 0, 0, 1, 0);
    chk("flush_dropped", 32'(out_valid), 0);

    step(1, I_BR2, 32'h400, 1, 0);
`ifdef ALU_DECODE_ILLEGAL_CHECK_EN
    chk("br010_illegal", 32'(illegal), 1);
    chk("br010_alu", 32'(alu_control), 32'h2);
`else
    chk("br010_illegal", 32'(illegal), 0);
`endif
    step(0, 0, 0, 1, 0);

    // Reset while two entries are buffered
    step(1, I_BEQ, 32'h500, 0, 0);
    step(1, I_SRAI, 32'h504, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      ins = rand_instr();
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
